riscv_state_dump: RTL and testbench
===================================

// Module: riscv_state_dump
// PURPOSE
//  Hardware state-dump responder for the RV32 core. A start pulse triggers a
//  streaming readout of the core's architectural state: register file x0..x31,
//  then data-memory bytes 0..DMEM_BYTES-1. Items go out on a valid/ready
//  stream, so a bench or debug link can capture the state without
//  hierarchical references. The core is stalled while a dump runs.
// PARAMETERS
//  XLEN        32   register width; also the width of out_data
//  NREGS       32   registers dumped (x0..x(NREGS-1))
//  DMEM_BYTES  32   data-memory bytes dumped (addresses 0..DMEM_BYTES-1)
//  DM_AW       32   data-memory byte-address width
// PORTS
//  clk        in   1      core clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      one-cycle dump request; ignored while busy
//  busy       out  1      dump in progress (any state other than IDLE)
//  halt_core  out  1      stalls PC/writeback; equals busy
//  done       out  1      one-cycle pulse after the last item's handshake
//  rf_raddr   out  5      register-file read address (combinational read port)
//  rf_rdata   in   XLEN   register-file read data, same cycle
//  dm_raddr   out  DM_AW  data-memory byte read address (combinational)
//  dm_rdata   in   8      data-memory byte, same cycle
//  out_valid  out  1      stream item valid
//  out_ready  in   1      sink ready
//  out_data   out  XLEN   register value, or memory byte zero-extended to XLEN
//  out_kind   out  1      0 = register item, 1 = memory item
//  out_index  out  8      register number or memory byte address
//  out_last   out  1      set only on the final memory item
// BEHAVIOUR
//  - Reset: state IDLE; idx=0; busy, halt_core, done, out_valid, out_last = 0;
//    out_data, out_kind, out_index = 0; rf_raddr, dm_raddr = 0.
//  - FSM states: IDLE -> REGS -> MEM -> DONE -> IDLE.
//    IDLE:  if start = 1, go to REGS with idx = 0.
//    REGS:  issue rf_raddr = idx. Stay until the item for idx = NREGS-1 is
//           loaded, then go to MEM with idx = 0.
//    MEM:   issue dm_raddr = idx. After the item for idx = DMEM_BYTES-1 is
//           loaded, stay until that item's handshake completes, then go to DONE.
//    DONE:  done = 1 for exactly one cycle, then go to IDLE.
//  - Output register: load when (!out_valid || out_ready) and there is an item
//    left to issue. A load captures rdata, kind, index and last, sets
//    out_valid and increments idx. Loads and handshakes can occur every cycle,
//    giving a throughput of 1 item per cycle.
//  - Handshake: a transfer occurs when out_valid && out_ready. While
//    out_valid = 1 and out_ready = 0, out_data, out_kind, out_index and
//    out_last hold stable. out_valid never drops without a transfer.
//  - Latency: start seen at edge t -> first out_valid at edge t+2.
//    With out_ready held at 1, done pulses NREGS+DMEM_BYTES+2 cycles after
//    start (66 with the default parameters).
//  - x0 is dumped as whatever rf_rdata returns; the register file guarantees 0.
//  - idx is internal only, with width clog2(max(NREGS,DMEM_BYTES))+1. It is
//    truncated onto out_index.
//  - start while busy: ignored, no queuing. start in the DONE cycle is also
//    ignored.
//  - rst mid-dump: immediate return to the reset state. The partial stream is
//    abandoned; no done pulse and no out_last.
//  - halt_core asserts in the REGS cycle and deasserts in the IDLE cycle
//    after DONE.
// STRUCTURE
//  - Shared package riscv_pkg: dump_state_t enum (IDLE, REGS, MEM, DONE);
//    constants DUMP_KIND_REG = 1'b0 and DUMP_KIND_MEM = 1'b1.
//  - Single module with no sub-modules. The output register plus load logic
//    is small enough to stay inline.
// TESTING
//  1. Preload x1..x31 = i*3 and MEM[i] = i+0x40. Pulse start with out_ready=1
//     -> 64 items in order: kind 0 for idx 0..31, then kind 1 for 0..31.
//     out_data matches the preload; out_last only on MEM[31]; done at
//     start+66 cycles.
//  2. Run program storing 0x07 to MEM[0], then dump -> item 32 has kind=1,
//     index=0, out_data=0x00000007. Item 0 (x0) has out_data=0.
//  3. Random out_ready (about 50% duty) -> same 64-item sequence. No item
//     changes while stalled; no drops or duplicates.
//  4. start pulsed again at item 10 -> ignored. Exactly 64 items and one done
//     pulse; busy and halt_core stay high throughout.
//  5. rst asserted at item 40 -> next cycle all outputs are at reset values.
//     A fresh start then restarts from x0.
//  6. out_ready=0 held for 20 cycles on item 0 -> out_valid=1 stable,
//     rf_raddr not advanced, halt_core=1. Release -> stream resumes at x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: state-dump FSM states and dump item kind codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REGS = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    localparam logic DUMP_KIND_REG = 1'b0;
    localparam logic DUMP_KIND_MEM = 1'b1;

endpackage

// File: rtl/riscv_state_dump.sv
// State-dump responder: streams x0..x(NREGS-1) then DMEM bytes on a valid/ready
// port while holding the core stalled.
module riscv_state_dump
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_BYTES = 32,
    parameter int DM_AW      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             halt_core,
    output logic             done,
    output logic [4:0]       rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic [DM_AW-1:0] dm_raddr,
    input  logic [7:0]       dm_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic             out_kind,
    output logic [7:0]       out_index,
    output logic             out_last
);

    localparam int IDX_MAX = (NREGS > DMEM_BYTES) ? NREGS : DMEM_BYTES;
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;

    dump_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_data_q, out_data_d;
    logic             out_kind_q, out_kind_d;
    logic [7:0]       out_index_q, out_index_d;
    logic             out_last_q, out_last_d;
    logic             can_load;
    logic             xfer;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_kind_d  = out_kind_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        can_load    = !out_valid_q || out_ready;
        xfer        = out_valid_q && out_ready;

        // A transfer empties the output register unless a new load refills it below.
        if (xfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REGS;
                    idx_d   = '0;
                end
            end
            REGS: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rf_rdata;
                    out_kind_d  = DUMP_KIND_REG;
                    out_index_d = 8'(idx_q);
                    out_last_d  = 1'b0;
                    if (idx_q == IDX_W'(NREGS - 1)) begin
                        state_d = MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            MEM: begin
                if (idx_q < IDX_W'(DMEM_BYTES)) begin
                    if (can_load) begin
                        out_valid_d = 1'b1;
                        out_data_d  = XLEN'(dm_rdata);
                        out_kind_d  = DUMP_KIND_MEM;
                        out_index_d = 8'(idx_q);
                        out_last_d  = (idx_q == IDX_W'(DMEM_BYTES - 1));
                        idx_d       = idx_q + IDX_W'(1);
                    end
                end else if (xfer && out_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_kind_q  <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_kind_q  <= out_kind_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Read addresses come straight from idx so the same-cycle read data is ready to load.
    assign rf_raddr  = (state_q == REGS) ? 5'(idx_q) : '0;
    assign dm_raddr  = (state_q == MEM) ? DM_AW'(idx_q) : '0;

    assign busy      = (state_q != IDLE);
    assign halt_core = busy;
    assign done      = (state_q == DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_kind  = out_kind_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_riscv_state_dump.sv
// Self-checking bench for riscv_state_dump: scenario table plus reset/stall sequences.
module tb_riscv_state_dump;
    import riscv_pkg::*;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int DMEM_BYTES = 32;
    localparam int DM_AW      = 32;
    localparam int NITEMS     = NREGS + DMEM_BYTES;
    localparam int BUDGET     = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             out_ready;
    logic             busy, halt_core, done;
    logic [4:0]       rf_raddr;
    logic [XLEN-1:0]  rf_rdata;
    logic [DM_AW-1:0] dm_raddr;
    logic [7:0]       dm_rdata;
    logic             out_valid;
    logic [XLEN-1:0]  out_data;
    logic             out_kind;
    logic [7:0]       out_index;
    logic             out_last;

    logic [XLEN-1:0]  rf_mem [NREGS];
    logic [7:0]       dmem   [DMEM_BYTES];

    int checks = 0;
    int errors = 0;

    riscv_state_dump #(
        .XLEN(XLEN), .NREGS(NREGS), .DMEM_BYTES(DMEM_BYTES), .DM_AW(DM_AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .halt_core(halt_core),
        .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dm_raddr(dm_raddr), .dm_rdata(dm_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_kind(out_kind),
        .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Register file with hardwired x0, byte-wide data memory; both read combinationally.
    assign rf_rdata = (rf_raddr == 5'd0) ? '0 : rf_mem[rf_raddr];
    assign dm_rdata = (dm_raddr < DM_AW'(DMEM_BYTES)) ? dmem[dm_raddr[4:0]] : 8'h00;

    function automatic logic [41:0] pack_item(logic [31:0] d, logic k, logic [7:0] i, logic l);
        return {d, k, i, l};
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Sink-side monitor: records transferred items, done pulses, valid rises, hold violations.
    int          cyc = 0;
    logic [41:0] got_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rise_cyc = 0;
    int          hold_err = 0;
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [42:0] prev_item = '0;
    logic [41:0] cur_item;

    assign cur_item = pack_item(out_data, out_kind, out_index, out_last);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (prev_stall && ({out_valid, cur_item} !== prev_item)) begin
                hold_err <= hold_err + 1;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(cur_item);
            end
            if (out_valid && !prev_valid) begin
                rise_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            prev_stall <= out_valid && !out_ready;
            prev_valid <= out_valid;
            prev_item  <= {1'b1, cur_item};
        end
    end

    typedef struct {
        string name;
        int    preset;        // 0: x_i=i*3, MEM[i]=i+0x40; 1: random; 2: random with MEM[0]=0x07
        int    pct;           // out_ready duty in percent
        int    restart_at;    // item count at which start is pulsed again (-1: never)
        bit    start_in_done; // pulse start during the done cycle
        int    stall0;        // cycles out_ready is held low after start
        int    exp_items;
        int    exp_dones;
        int    exp_done_lat;  // -1: not checked
        int    exp_first_lat; // -1: not checked
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_preset(input int p);
        for (int i = 0; i < NREGS; i++) rf_mem[i] = (p == 0) ? XLEN'(i * 3) : $urandom;
        for (int i = 0; i < DMEM_BYTES; i++) dmem[i] = (p == 0) ? 8'(i + 'h40) : 8'($urandom);
        if (p == 2) dmem[0] = 8'h07;
    endtask

    task automatic run_dump(input vec_t v);
        logic [41:0] exp_q[$];
        int base_items;
        int base_done;
        int t0;
        int b;
        int n;
        bit busy_ok;
        bit pulsed;
        base_items = got_q.size();
        base_done  = done_cnt;
        busy_ok    = 1'b1;
        pulsed     = 1'b0;

        // Reference stream: every register in order, then every memory byte, last on the final byte.
        for (int i = 0; i < NREGS; i++)
            exp_q.push_back(pack_item((i == 0) ? 32'd0 : rf_mem[i], DUMP_KIND_REG, 8'(i), 1'b0));
        for (int i = 0; i < DMEM_BYTES; i++)
            exp_q.push_back(pack_item({24'd0, dmem[i]}, DUMP_KIND_MEM, 8'(i), i == DMEM_BYTES - 1));

        start     = 1'b1;
        out_ready = (v.stall0 > 0) ? 1'b0 : ($urandom_range(99) < v.pct);
        t0        = cyc;
        tick();
        start = 1'b0;
        b = 0;
        while (done_cnt == base_done && b < BUDGET) begin
            if (!(busy && halt_core)) busy_ok = 1'b0;
            if (v.stall0 > 0 && b == v.stall0) begin
                check({v.name, "_stall_valid"}, out_valid, 1);
                check({v.name, "_stall_item"}, cur_item, pack_item(32'd0, DUMP_KIND_REG, 8'd0, 1'b0));
                check({v.name, "_stall_raddr"}, rf_raddr, 1);
                check({v.name, "_stall_halt"}, halt_core, 1);
            end
            if (!pulsed && v.restart_at >= 0 && got_q.size() - base_items >= v.restart_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = v.start_in_done && done;
            end
            out_ready = (b < v.stall0) ? 1'b0 : ($urandom_range(99) < v.pct);
            tick();
            b++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        n = got_q.size() - base_items;
        check({v.name, "_timeout"}, b < BUDGET, 1);
        check({v.name, "_items"}, n, v.exp_items);
        check({v.name, "_dones"}, done_cnt - base_done, v.exp_dones);
        check({v.name, "_busy_during"}, busy_ok, 1);
        check({v.name, "_idle_after"}, {busy, halt_core, out_valid}, 0);
        for (int i = 0; i < v.exp_items && i < n; i++)
            check($sformatf("%s_item%0d", v.name, i), got_q[base_items + i], exp_q[i]);
        if (v.exp_done_lat >= 0) begin
            check({v.name, "_done_lat"}, done_cyc - t0, v.exp_done_lat);
            check({v.name, "_first_lat"}, rise_cyc - t0, v.exp_first_lat);
        end
        $display("dump %s: items=%0d dones=%0d cycles=%0d", v.name, n, done_cnt - base_done, b);
    endtask

    task automatic reset_mid_dump();
        int base_items;
        int base_done;
        int b;
        bit last_seen;
        base_items = got_q.size();
        base_done  = done_cnt;
        last_seen  = 1'b0;
        load_preset(1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        b = 0;
        while (got_q.size() - base_items < 40 && b < BUDGET) begin
            tick();
            b++;
        end
        check("rstmid_reach40", b < BUDGET, 1);
        rst = 1'b1;
        tick();
        check("rstmid_ctrl", {busy, halt_core, done, out_valid, out_last, out_kind}, 0);
        check("rstmid_data", out_data, 0);
        check("rstmid_index", out_index, 0);
        check("rstmid_addr", {rf_raddr, dm_raddr}, 0);
        rst = 1'b0;
        repeat (3) tick();
        for (int i = base_items; i < got_q.size(); i++) if (got_q[i][0]) last_seen = 1'b1;
        check("rstmid_no_done", done_cnt - base_done, 0);
        check("rstmid_no_last", last_seen, 0);
        check("rstmid_partial", got_q.size() - base_items < NITEMS, 1);
        check("rstmid_idle", {busy, out_valid}, 0);
        $display("reset mid-dump: partial items=%0d", got_q.size() - base_items);
    endtask

    initial begin
        vec_t v;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        load_preset(0);
        repeat (3) tick();
        check("rst_ctrl", {busy, halt_core, done, out_valid, out_last, out_kind}, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_addr", {rf_raddr, dm_raddr}, 0);
        rst = 1'b0;
        tick();
        check("idle_no_start", {busy, halt_core, done, out_valid}, 0);
        $display("reset: outputs checked");

        tbl[0] = '{"preload",         0, 100, -1, 1'b0,  0, NITEMS, 1, 66, 2};
        tbl[1] = '{"mem0_store",      2, 100, -1, 1'b0,  0, NITEMS, 1, 66, 2};
        tbl[2] = '{"rand_ready",      1,  50, -1, 1'b0,  0, NITEMS, 1, -1, -1};
        tbl[3] = '{"restart_ignored", 1, 100, 10, 1'b1,  0, NITEMS, 1, 66, 2};
        tbl[4] = '{"stall_x0",        0, 100, -1, 1'b0, 20, NITEMS, 1, -1, -1};
        tbl[5] = '{"rand_low_restart",1,  30,  5, 1'b1,  0, NITEMS, 1, -1, -1};

        for (int i = 0; i < 6; i++) begin
            load_preset(tbl[i].preset);
            run_dump(tbl[i]);
        end

        reset_mid_dump();
        v      = tbl[0];
        v.name = "fresh_after_rst";
        load_preset(1);
        run_dump(v);

        check("hold_stable", hold_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
